// File: rtl/ps2_key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_pkg
// Brief    : Shared constants, key-event layout and decoder state encoding
//            for the PS/2 scan-code FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_key_pkg;

  // Prefix and error bytes emitted by the PS/2 controller
  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  // Key event word: {ext, brk, code[7:0]}
  localparam int KEY_W   = 10;
  localparam int KEY_EXT = 9;
  localparam int KEY_BRK = 8;

  // Decoder state: which prefixes have been seen for the current key
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_e;

  // Bytes that signal a receive error and abandon any pending prefix
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : key_sync_fifo
// Brief    : Single-clock circular FIFO with occupancy counter. A push into
//            a full FIFO is accepted only when a valid pop frees a slot in
//            the same cycle; otherwise it is reported on 'drop'.
// Revision : 1.0 - initial release
// ============================================================================
module key_sync_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             drop
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  // Arbitration, next-pointer/count and storage write computation
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    drop     = push && !push_ok;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Head is masked to zero so stale storage never leaks out when empty
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
    count   = count_q;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; no reset needed because the read port is masked when empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_fifo
// Brief    : Folds PS/2 E0/F0 prefixes into single key events, filters break
//            events, and queues the result for the processor with a sticky
//            overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_fifo
  import ps2_key_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter bit KEEP_BREAK = 1'b0
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [7:0]                 ps2_key_data,
  input  logic                       ps2_key_pressed,
  input  logic                       key_pop,
  input  logic                       clear_overflow,
  output logic                       key_valid,
  output logic [KEY_W-1:0]           key_data,
  output logic [$clog2(DEPTH+1)-1:0] key_count,
  output logic                       overflow
);

  dec_state_e       state_q, state_d;
  logic             emit;
  logic             emit_ext;
  logic             emit_brk;
  logic             push;
  logic [KEY_W-1:0] event_word;
  logic             fifo_empty;
  logic             fifo_drop;
  logic             overflow_q, overflow_d;

  // Prefix decoder: next state and key-event emission on each strobed byte
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (ps2_key_pressed) begin
      if (is_err_byte(ps2_key_data)) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ps2_key_data == PS2_EXT)      state_d = ST_EXT;
            else if (ps2_key_data == PS2_BRK) state_d = ST_BRK;
            else                              emit    = 1'b1;
          end
          ST_EXT: begin
            if (ps2_key_data == PS2_BRK)      state_d = ST_EXT_BRK;
            else if (ps2_key_data == PS2_EXT) state_d = ST_EXT;
            else begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              state_d  = ST_IDLE;
            end
          end
          ST_BRK: begin
            if (ps2_key_data == PS2_BRK)      state_d = ST_BRK;
            else if (ps2_key_data == PS2_EXT) state_d = ST_EXT;
            else begin
              emit     = 1'b1;
              emit_brk = 1'b1;
              state_d  = ST_IDLE;
            end
          end
          ST_EXT_BRK: begin
            if ((ps2_key_data == PS2_EXT) || (ps2_key_data == PS2_BRK)) begin
              state_d = ST_EXT;
            end else begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              emit_brk = 1'b1;
              state_d  = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
    event_word = {emit_ext, emit_brk, ps2_key_data};
    // Suppressed breaks never reach the FIFO, so they cannot overflow it
    push       = emit && (!emit_brk || KEEP_BREAK);
  end

  // Decoder state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Sticky overflow: a new drop takes priority over a same-cycle clear
  always_comb begin
    overflow_d = overflow_q;
    if (clear_overflow) overflow_d = 1'b0;
    if (fifo_drop)      overflow_d = 1'b1;
  end

  // Overflow flag register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end

  key_sync_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (resetn),
    .push      (push),
    .push_data (event_word),
    .pop       (key_pop),
    .rd_data   (key_data),
    .empty     (fifo_empty),
    .count     (key_count),
    .drop      (fifo_drop)
  );

  assign key_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_fifo
// Brief    : Self-checking bench: two instances (break events kept / dropped)
//            driven by shared stimulus, compared each cycle against a
//            queue-based event model, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_fifo;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             resetn;
  logic [7:0]       data;
  logic             pressed;
  logic             pop;
  logic             clr;

  logic             kv1, kv0;
  logic [9:0]       kd1, kd0;
  logic [CNT_W-1:0] kc1, kc0;
  logic             ov1, ov0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ps2_key_fifo #(.DEPTH(DEPTH), .KEEP_BREAK(1'b1)) u_dut_kb (
    .clock(clock), .resetn(resetn), .ps2_key_data(data), .ps2_key_pressed(pressed),
    .key_pop(pop), .clear_overflow(clr), .key_valid(kv1), .key_data(kd1),
    .key_count(kc1), .overflow(ov1));

  ps2_key_fifo #(.DEPTH(DEPTH), .KEEP_BREAK(1'b0)) u_dut_mk (
    .clock(clock), .resetn(resetn), .ps2_key_data(data), .ps2_key_pressed(pressed),
    .key_pop(pop), .clear_overflow(clr), .key_valid(kv0), .key_data(kd0),
    .key_count(kc0), .overflow(ov0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Prefix state kept as two flags: "E0 seen" and "F0 seen".
  typedef logic [9:0] evq_t[$];
  evq_t mq1, mq0;
  bit   ext1, brk1, ovf1;
  bit   ext0, brk0, ovf0;

  task automatic model_step(input bit keep, ref evq_t q, ref bit ext, ref bit brk, ref bit ovf);
    bit         pop_ok;
    bit         want;
    bit         dropped;
    logic [9:0] ev;
    pop_ok  = pop && (q.size() > 0);
    want    = 1'b0;
    dropped = 1'b0;
    ev      = '0;
    if (pressed) begin
      if (data == 8'h00 || data == 8'hFF) begin
        ext = 0; brk = 0;
      end else if (data == 8'hE0) begin
        ext = 1; brk = 0;
      end else if (data == 8'hF0) begin
        if (ext && brk) brk = 0;
        else            brk = 1;
      end else begin
        ev   = {ext, brk, data};
        want = !brk || keep;
        ext  = 0; brk = 0;
      end
    end
    if (pop_ok) void'(q.pop_front());
    if (want) begin
      if (q.size() < DEPTH) q.push_back(ev);
      else                  dropped = 1'b1;
    end
    if (clr)     ovf = 1'b0;
    if (dropped) ovf = 1'b1;
  endtask

  always @(posedge clock) begin
    if (!resetn) begin
      mq1.delete(); mq0.delete();
      ext1 = 0; brk1 = 0; ovf1 = 0;
      ext0 = 0; brk0 = 0; ovf0 = 0;
    end else begin
      model_step(1'b1, mq1, ext1, brk1, ovf1);
      model_step(1'b0, mq0, ext0, brk0, ovf0);
    end
  end

  task automatic cmp_dut(input string tag, input logic kv, input logic [9:0] kd,
                         input logic [CNT_W-1:0] kc, input logic ov,
                         input evq_t q, input bit ovf);
    logic [9:0] exp_kd;
    exp_kd = (q.size() > 0) ? q[0] : 10'h000;
    chk({tag, " key_valid"}, 32'(kv), 32'(q.size() > 0));
    chk({tag, " key_data"},  32'(kd), 32'(exp_kd));
    chk({tag, " key_count"}, 32'(kc), 32'(q.size()));
    chk({tag, " overflow"},  32'(ov), 32'(ovf));
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    cmp_dut("kb", kv1, kd1, kc1, ov1, mq1, ovf1);
    cmp_dut("mk", kv0, kd0, kc0, ov0, mq0, ovf0);
  end

  // ---------------- stimulus helpers ----------------
  // Called at negedge+1; drives one cycle, returns at the next negedge+1.
  task automatic cyc(input bit p, input logic [7:0] d, input bit po, input bit c);
    pressed = p; data = d; pop = po; clr = c;
    @(negedge clock); #1;
    pressed = 0; data = 8'h00; pop = 0; clr = 0;
  endtask

  task automatic pulse_reset();
    pressed = 0; pop = 0; clr = 0;
    resetn = 0;
    @(negedge clock); #1;
    resetn = 1;
  endtask

  task automatic lit(input string name, input logic kv, input logic [9:0] kd,
                     input logic [CNT_W-1:0] kc, input logic ov,
                     input logic e_kv, input logic [9:0] e_kd,
                     input logic [CNT_W-1:0] e_kc, input logic e_ov);
    chk({name, " valid"}, 32'(kv), 32'(e_kv));
    chk({name, " data"},  32'(kd), 32'(e_kd));
    chk({name, " count"}, 32'(kc), 32'(e_kc));
    chk({name, " ovf"},   32'(ov), 32'(e_ov));
  endtask

  logic [9:0] exp_order [8];

  initial begin
    resetn = 0; pressed = 0; data = 8'h00; pop = 0; clr = 0;
    repeat (2) @(negedge clock);
    #1;
    lit("reset kb", kv1, kd1, kc1, ov1, 1'b0, 10'h000, 4'd0, 1'b0);
    resetn = 1;
    @(negedge clock); #1;

    // Single make code, then pop
    cyc(1, 8'h1C, 0, 0);
    lit("1C kb", kv1, kd1, kc1, ov1, 1'b1, 10'h01C, 4'd1, 1'b0);
    lit("1C mk", kv0, kd0, kc0, ov0, 1'b1, 10'h01C, 4'd1, 1'b0);
    cyc(0, 8'h00, 1, 0);
    lit("1C pop", kv1, kd1, kc1, ov1, 1'b0, 10'h000, 4'd0, 1'b0);

    // Extended make and extended break
    cyc(1, 8'hE0, 0, 0); cyc(1, 8'h75, 0, 0);
    cyc(1, 8'hE0, 0, 0); cyc(1, 8'hF0, 0, 0); cyc(1, 8'h75, 0, 0);
    lit("ext kb", kv1, kd1, kc1, ov1, 1'b1, 10'h275, 4'd2, 1'b0);
    lit("ext mk", kv0, kd0, kc0, ov0, 1'b1, 10'h275, 4'd1, 1'b0);
    cyc(0, 8'h00, 1, 0);
    lit("extbrk kb", kv1, kd1, kc1, ov1, 1'b1, 10'h375, 4'd1, 1'b0);
    lit("extbrk mk", kv0, kd0, kc0, ov0, 1'b0, 10'h000, 4'd0, 1'b0);
    cyc(0, 8'h00, 1, 0);

    // Fill past capacity
    for (int i = 1; i <= 9; i++) cyc(1, 8'(i), 0, 0);
    lit("full kb", kv1, kd1, kc1, ov1, 1'b1, 10'h001, 4'd8, 1'b1);
    lit("full mk", kv0, kd0, kc0, ov0, 1'b1, 10'h001, 4'd8, 1'b1);
    cyc(0, 8'h00, 0, 1);
    lit("clr kb", kv1, kd1, kc1, ov1, 1'b1, 10'h001, 4'd8, 1'b0);

    // Push + pop while full: accepted, no overflow
    cyc(1, 8'h2A, 1, 0);
    lit("fullpp kb", kv1, kd1, kc1, ov1, 1'b1, 10'h002, 4'd8, 1'b0);
    for (int i = 0; i < 7; i++) exp_order[i] = 10'(i + 2);
    exp_order[7] = 10'h02A;
    for (int i = 0; i < 8; i++) begin
      chk("drain order", 32'(kd1), 32'(exp_order[i]));
      cyc(0, 8'h00, 1, 0);
    end
    lit("drained kb", kv1, kd1, kc1, ov1, 1'b0, 10'h000, 4'd0, 1'b0);

    // Error byte discards prefix
    cyc(1, 8'hF0, 0, 0); cyc(1, 8'hFF, 0, 0); cyc(1, 8'h1C, 0, 0);
    lit("err kb", kv1, kd1, kc1, ov1, 1'b1, 10'h01C, 4'd1, 1'b0);
    cyc(0, 8'h00, 1, 0);

    // Reset discards prefix
    cyc(1, 8'hE0, 0, 0);
    pulse_reset();
    cyc(1, 8'h1C, 0, 0);
    lit("rstpfx kb", kv1, kd1, kc1, ov1, 1'b1, 10'h01C, 4'd1, 1'b0);
    cyc(0, 8'h00, 1, 0);

    // Pop on empty with simultaneous push
    cyc(1, 8'h1C, 1, 0);
    lit("emptypp kb", kv1, kd1, kc1, ov1, 1'b1, 10'h01C, 4'd1, 1'b0);
    lit("emptypp mk", kv0, kd0, kc0, ov0, 1'b1, 10'h01C, 4'd1, 1'b0);
    cyc(0, 8'h00, 1, 0);

    // Randomized traffic, alternating fill-heavy and drain-heavy phases
    for (int i = 0; i < 4000; i++) begin
      int r;
      int pop_pct;
      logic [7:0] b;
      pop_pct = ((i / 400) % 2 == 0) ? 15 : 70;
      if ($urandom_range(0, 999) == 0) begin
        pulse_reset();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 15)      b = 8'hE0;
        else if (r < 30) b = 8'hF0;
        else if (r < 32) b = 8'h00;
        else if (r < 34) b = 8'hFF;
        else             b = 8'($urandom_range(1, 254));
        cyc(($urandom_range(0, 99) < 60), b,
            ($urandom_range(0, 99) < pop_pct),
            ($urandom_range(0, 99) < 5));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
